// File: rtl/uart_tx_io.sv
// rtl/uart_tx_io.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status word
module uart_tx_io #(
    parameter int CLK_FREQ_HZ = 27000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_wr,
    output logic [31:0] io_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);
    localparam int DIV   = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        mem [FIFO_DEPTH];

    logic       sel, push, push_ok, pop, full, empty;
    logic [7:0] head, level8;
    logic       unused_bits;

    assign sel    = io_addr[22] & io_addr[3];
    assign push   = io_wr & sel;
    assign full   = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty  = (level_q == '0);
    assign head   = mem[rd_ptr_q];
    assign level8 = 8'(level_q);
    assign unused_bits = ^{io_addr[31:23], io_addr[21:4], io_addr[2:0], io_wdata[31:8]};

    // Serialiser: the line value is decided one cycle ahead so uart_tx is a flop output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = CNT_RELOAD;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_RELOAD;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        cnt_d   = CNT_RELOAD;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
    always_comb begin
        push_ok    = push & (!full | pop);
        overflow_d = overflow_q | (push & full & !pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q + LVL_W'(push_ok) - LVL_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= io_wdata[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    assign uart_tx  = tx_q;
    assign tx_busy  = !empty | (state_q != IDLE);
    assign io_rdata = sel ? {21'b0, overflow_q, full, tx_busy, level8} : 32'b0;
endmodule

// File: tb/tb_uart_tx_io.sv
// tb/tb_uart_tx_io.sv - randomized directed bench for uart_tx_io against a frame-arithmetic model
module tb_uart_tx_io;
    localparam logic [31:0] STAT = 32'h0040_0008;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] io_addr = STAT;
    logic [31:0] io_wdata = 32'b0;
    logic        io_wr = 1'b0;
    logic [31:0] io_rdata;
    logic        uart_tx;
    logic        tx_busy;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    uart_tx_io #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_wr(io_wr), .io_rdata(io_rdata), .uart_tx(uart_tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge; drives one store for the next posedge, returns one negedge later.
    task automatic store(input logic [31:0] a, input logic [7:0] d);
        io_addr  = a;
        io_wdata = {24'($urandom()), d};
        io_wr    = 1'b1;
        @(negedge clk);
        io_wr    = 1'b0;
        io_addr  = STAT;
    endtask

    // Called at the negedge where the first start bit is visible; 10 slots of 10 cycles per frame.
    task automatic check_line(input int nf);
        logic [7:0] cur;
        logic       e;
        int         s;
        cur = 8'h00;
        for (int i = 0; i < nf * 100; i++) begin
            s = (i % 100) / 10;
            if (i % 100 == 0) begin
                chk("exp_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
            end
            if (s == 0)      e = 1'b0;
            else if (s == 9) e = 1'b1;
            else             e = cur[s-1];
            chk("line", {31'b0, uart_tx}, {31'b0, e});
            chk("busy_in_frame", {31'b0, tx_busy}, 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] b[6];

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_tx", {31'b0, uart_tx}, 32'd1);
        chk("reset_busy", {31'b0, tx_busy}, 32'd0);
        chk("reset_status", io_rdata, 32'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x55
        store(STAT, 8'h55);
        chk("single_status_e0", io_rdata, 32'h101);
        chk("single_tx_e0", {31'b0, uart_tx}, 32'd1);
        @(negedge clk);
        exp_q.push_back(8'h55);
        check_line(1);
        chk("single_idle_tx", {31'b0, uart_tx}, 32'd1);
        chk("single_idle_busy", {31'b0, tx_busy}, 32'd0);
        chk("single_idle_status", io_rdata, 32'h0);
        repeat (3) @(negedge clk);

        // Back-to-back: fixed bytes then random bytes
        for (int it = 0; it < 2; it++) begin
            for (int k = 0; k < 3; k++) b[k] = (it == 0) ? 8'(8'h41 + k) : 8'($urandom());
            for (int k = 0; k < 3; k++) exp_q.push_back(b[k]);
            fork
                begin
                    for (int k = 0; k < 3; k++) store(STAT, b[k]);
                    chk("b2b_level2", io_rdata, 32'h102);
                    repeat (99) @(negedge clk);
                    chk("b2b_level1", io_rdata, 32'h101);
                    repeat (100) @(negedge clk);
                    chk("b2b_level0", io_rdata, 32'h100);
                end
                begin
                    repeat (2) @(negedge clk);
                    check_line(3);
                end
            join
            chk("b2b_done_busy", {31'b0, tx_busy}, 32'd0);
            chk("b2b_done_status", io_rdata, 32'h0);
            repeat (2) @(negedge clk);
        end

        // Overflow: six stores, the sixth is dropped
        for (int k = 0; k < 6; k++) b[k] = 8'($urandom());
        for (int k = 0; k < 5; k++) exp_q.push_back(b[k]);
        fork
            begin
                for (int k = 0; k < 6; k++) store(STAT, b[k]);
                chk("ovf_status", io_rdata, 32'h704);
            end
            begin
                repeat (2) @(negedge clk);
                check_line(5);
            end
        join
        chk("ovf_idle_tx", {31'b0, uart_tx}, 32'd1);
        chk("ovf_sticky", io_rdata, 32'h400);
        repeat (5) @(negedge clk);
        chk("ovf_no_sixth_frame", {31'b0, uart_tx}, 32'd1);

        // Reset during data bit 3 (bit forced to 0 so the line is low when reset hits)
        b[0] = 8'($urandom()) & 8'hF7;
        store(STAT, b[0]);
        repeat (44) @(negedge clk);
        chk("rst_pre_line_low", {31'b0, uart_tx}, 32'd0);
        resetn = 1'b0;
        #1;
        chk("rst_async_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_async_busy", {31'b0, tx_busy}, 32'd0);
        chk("rst_async_status", io_rdata, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        b[0] = 8'($urandom());
        exp_q.push_back(b[0]);
        store(STAT, b[0]);
        @(negedge clk);
        check_line(1);
        chk("rst_after_status", io_rdata, 32'h0);

        // Full FIFO, store lands on the STOP->START pop edge
        for (int k = 0; k < 6; k++) b[k] = 8'($urandom());
        for (int k = 0; k < 6; k++) exp_q.push_back(b[k]);
        fork
            begin
                for (int k = 0; k < 5; k++) store(STAT, b[k]);
                chk("full_status", io_rdata, 32'h304);
                repeat (96) @(negedge clk);
                store(STAT, b[5]);
                chk("full_pushpop_status", io_rdata, 32'h304);
            end
            begin
                repeat (2) @(negedge clk);
                check_line(6);
            end
        join
        chk("full_done_status", io_rdata, 32'h0);
        chk("full_done_busy", {31'b0, tx_busy}, 32'd0);

        // Address decode
        io_wdata = {24'($urandom()), 8'hA5};
        io_addr  = 32'h0040_0004;
        io_wr    = 1'b1;
        #1;
        chk("decode_other_io_rdata", io_rdata, 32'h0);
        @(negedge clk);
        io_addr = 32'h0000_0008;
        #1;
        chk("decode_ram_rdata", io_rdata, 32'h0);
        @(negedge clk);
        io_wr   = 1'b0;
        io_addr = STAT;
        repeat (5) @(negedge clk);
        chk("decode_no_push_status", io_rdata, 32'h0);
        chk("decode_no_push_tx", {31'b0, uart_tx}, 32'd1);
        chk("decode_no_push_busy", {31'b0, tx_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
